// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display controller: segment codes,
// field encodings, FSM states and the nibble-to-segment lookup.
package seg_pkg;

  localparam int NUM_DIGITS = 6;

  // Active-low segment codes {dp, g..a} with the decimal point off
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_SEC  = 2'd1,
    FIELD_MIN  = 2'd2,
    FIELD_HOUR = 2'd3
  } field_e;

  typedef enum logic {
    ST_TIME = 1'b0,
    ST_MSG  = 1'b1
  } state_e;

  function automatic logic [6:0] seg_lookup(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0:    code = SEG_0;
      4'h1:    code = SEG_1;
      4'h2:    code = SEG_2;
      4'h3:    code = SEG_3;
      4'h4:    code = SEG_4;
      4'h5:    code = SEG_5;
      4'h6:    code = SEG_6;
      4'h7:    code = SEG_7;
      4'h8:    code = SEG_8;
      4'h9:    code = SEG_9;
      4'hA:    code = SEG_A;
      4'hB:    code = SEG_B;
      4'hC:    code = SEG_C;
      4'hD:    code = SEG_D;
      4'hE:    code = SEG_E;
      default: code = SEG_F;
    endcase
    return code[6:0];
  endfunction

endpackage

// File: rtl/seg_disp_ctrl_if.sv
// Bus between the time/message sources (master) and the display controller
// (slave), including the six segment outputs feeding the scanner.
interface seg_disp_ctrl_if;

  logic [23:0] time_bcd;
  logic        time_valid;
  logic [1:0]  edit_field;
  logic        msg_req;
  logic [23:0] msg_data;
  logic        msg_ack;
  logic        msg_busy;
  logic [7:0]  seg_data_0;
  logic [7:0]  seg_data_1;
  logic [7:0]  seg_data_2;
  logic [7:0]  seg_data_3;
  logic [7:0]  seg_data_4;
  logic [7:0]  seg_data_5;

  modport master (
    output time_bcd, time_valid, edit_field, msg_req, msg_data,
    input  msg_ack, msg_busy,
    input  seg_data_0, seg_data_1, seg_data_2, seg_data_3, seg_data_4, seg_data_5
  );

  modport slave (
    input  time_bcd, time_valid, edit_field, msg_req, msg_data,
    output msg_ack, msg_busy,
    output seg_data_0, seg_data_1, seg_data_2, seg_data_3, seg_data_4, seg_data_5
  );

endinterface

// File: rtl/seg_hex_decode.sv
// One digit of hex-to-seven-segment decode: nibble plus active-low dp in,
// active-low {dp, g..a} code out.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp_n,
  output logic [7:0] seg_n
);

  assign seg_n = {dp_n, seg_lookup(nibble)};

endmodule

// File: rtl/seg_disp_ctrl.sv
// Six-digit display controller: shows the RTC time or a timed one-shot message.
// Define SEG_DISP_BLINK_EN to compile in blinking of the field being edited.
module seg_disp_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BLINK_MS    = 250,
  parameter int MSG_HOLD_MS = 2000
) (
  input  logic             clk,
  input  logic             rst_n,
  seg_disp_ctrl_if.slave   bus
);

  localparam int MS_DIV = CLK_FREQ / 1000;
  localparam int PRE_W  = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(MS_DIV - 1);

  localparam int HOLD_W = (MSG_HOLD_MS > 1) ? $clog2(MSG_HOLD_MS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MSG_HOLD_MS - 1);

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              ms_tick;

  state_e            state_q, state_d;
  logic [23:0]       time_q, time_d;
  logic [23:0]       msg_q, msg_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;

  logic [NUM_DIGITS-1:0][7:0] seg_q, seg_d;
  logic [NUM_DIGITS-1:0][7:0] dec_code;
  logic [23:0]                disp_nib;
  logic [NUM_DIGITS-1:0]      dp_n;
  logic [NUM_DIGITS-1:0]      blank;

  always_comb begin
    ms_tick = (pre_q == PRE_MAX);
    pre_d   = ms_tick ? '0 : pre_q + 1'b1;
  end

  // Time latch runs in every state; a request in TIME is accepted the same
  // cycle it is seen, so a time strobe and a request can land together.
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    hold_d  = hold_q;
    ack_d   = 1'b0;
    time_d  = bus.time_valid ? bus.time_bcd : time_q;
    busy_d  = (state_q == ST_MSG);

    case (state_q)
      ST_TIME: begin
        if (bus.msg_req) begin
          ack_d   = 1'b1;
          msg_d   = bus.msg_data;
          hold_d  = '0;
          state_d = ST_MSG;
        end
      end
      ST_MSG: begin
        if (ms_tick) begin
          if (hold_q == HOLD_MAX) begin
            state_d = ST_TIME;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: state_d = ST_TIME;
    endcase
  end

  // Separators sit on digits 2 and 4 (between ss/mm and mm/hh) in TIME only.
  always_comb begin
    disp_nib = (state_q == ST_MSG) ? msg_q : time_q;
    dp_n     = (state_q == ST_MSG) ? 6'b111111 : 6'b101011;
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
    seg_hex_decode u_dec (
      .nibble (disp_nib[4*i +: 4]),
      .dp_n   (dp_n[i]),
      .seg_n  (dec_code[i])
    );
  end

`ifdef SEG_DISP_BLINK_EN
  localparam int BLK_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_MS - 1);

  logic [BLK_W-1:0] blk_q, blk_d;
  logic             blink_on_q, blink_on_d;
  field_e           edit_q, edit_d;

  // Blanking follows the registered field so a field switch never blanks
  // the newly selected pair before the forced-visible phase takes effect.
  always_comb begin
    edit_d     = field_e'(bus.edit_field);
    blk_d      = blk_q;
    blink_on_d = blink_on_q;
    if (edit_d != edit_q) begin
      blk_d      = '0;
      blink_on_d = 1'b1;
    end else if (ms_tick) begin
      if (blk_q == BLK_MAX) begin
        blk_d      = '0;
        blink_on_d = ~blink_on_q;
      end else begin
        blk_d = blk_q + 1'b1;
      end
    end

    blank = '0;
    if ((state_q == ST_TIME) && !blink_on_q) begin
      case (edit_q)
        FIELD_SEC:  blank = 6'b000011;
        FIELD_MIN:  blank = 6'b001100;
        FIELD_HOUR: blank = 6'b110000;
        default:    blank = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q      <= '0;
      blink_on_q <= 1'b1;
      edit_q     <= FIELD_NONE;
    end else begin
      blk_q      <= blk_d;
      blink_on_q <= blink_on_d;
      edit_q     <= edit_d;
    end
  end
`else
  logic unused_edit;
  assign unused_edit = ^bus.edit_field;
  assign blank       = '0;
`endif

  always_comb begin
    seg_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      seg_d[i] = blank[i] ? SEG_BLANK : dec_code[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      state_q <= ST_TIME;
      time_q  <= '0;
      msg_q   <= '0;
      hold_q  <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      seg_q   <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      pre_q   <= pre_d;
      state_q <= state_d;
      time_q  <= time_d;
      msg_q   <= msg_d;
      hold_q  <= hold_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.msg_ack    = ack_q;
  assign bus.msg_busy   = busy_q;
  assign bus.seg_data_0 = seg_q[0];
  assign bus.seg_data_1 = seg_q[1];
  assign bus.seg_data_2 = seg_q[2];
  assign bus.seg_data_3 = seg_q[3];
  assign bus.seg_data_4 = seg_q[4];
  assign bus.seg_data_5 = seg_q[5];

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Bench for seg_disp_ctrl at 10 kHz (1 ms = 10 cycles), blink 2 ms, hold 5 ms.
// Blink checks apply when SEG_DISP_BLINK_EN is defined; otherwise steadiness is checked.
module tb_seg_disp_ctrl;

  localparam int CLK_FREQ    = 10_000;
  localparam int BLINK_MS    = 2;
  localparam int MSG_HOLD_MS = 5;

  // Expected displays packed {d5,d4,d3,d2,d1,d0}
  localparam logic [47:0] EXP_ZERO       = 48'hC040C040C0C0;
  localparam logic [47:0] EXP_T235907    = 48'hA4309210C0F8;
  localparam logic [47:0] EXP_T123456    = 48'hF924B0199282;
  localparam logic [47:0] EXP_MSG_ABCDEF = 48'h8883C6A1868E;
  localparam logic [47:0] EXP_MSG_123456 = 48'hF9A4B0999282;
  localparam logic [47:0] EXP_MSG_ZERO   = 48'hC0C0C0C0C0C0;
  localparam logic [47:0] ALL_BLANK      = 48'hFFFFFFFFFFFF;

  typedef struct {
    logic [23:0] bcd;
    logic [47:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [47:0] sb_q[$];
  vec_t vecs[5];

  int   dur, errs, acks, ntr, run;
  bit   ok, blank2, prev_blank, saw45;
  logic [47:0] s;

  seg_disp_ctrl_if bus();

  seg_disp_ctrl #(
    .CLK_FREQ    (CLK_FREQ),
    .BLINK_MS    (BLINK_MS),
    .MSG_HOLD_MS (MSG_HOLD_MS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [47:0] segs();
    return {bus.seg_data_5, bus.seg_data_4, bus.seg_data_3,
            bus.seg_data_2, bus.seg_data_1, bus.seg_data_0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic sb_check(input string name);
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, got %0h", name, segs());
    end else begin
      chk(name, segs(), sb_q.pop_front());
    end
  endtask

  // Pulse time_valid at a negedge; returns at the negedge two active edges later.
  task automatic set_time(input logic [23:0] bcd);
    bus.time_bcd   = bcd;
    bus.time_valid = 1'b1;
    @(negedge clk);
    bus.time_valid = 1'b0;
    @(negedge clk);
  endtask

  // Called while busy is high: counts busy cycles until it drops.
  task automatic ride_msg(input logic [47:0] exp_msg, output int d, output int e, output int a);
    d = 1;
    e = 0;
    a = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (!bus.msg_busy) return;
      d++;
      if (segs() !== exp_msg) e++;
      if (bus.msg_ack) a++;
    end
    chk("msg_busy_timeout", bus.msg_busy, 1'b0);
  endtask

  initial begin
    vecs[0] = '{bcd: 24'h000000, exp: EXP_ZERO};
    vecs[1] = '{bcd: 24'h123456, exp: EXP_T123456};
    vecs[2] = '{bcd: 24'h0189AB, exp: 48'hC07980108883};
    vecs[3] = '{bcd: 24'h987654, exp: 48'h9000F8029299};
    vecs[4] = '{bcd: 24'h235907, exp: EXP_T235907};

    bus.time_bcd   = '0;
    bus.time_valid = 1'b0;
    bus.edit_field = 2'd0;
    bus.msg_req    = 1'b0;
    bus.msg_data   = '0;

    repeat (3) @(negedge clk);
    chk("reset_seg", segs(), ALL_BLANK);
    chk("reset_ack", bus.msg_ack, 1'b0);
    chk("reset_busy", bus.msg_busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_seg", segs(), EXP_ZERO);
    chk("post_reset_ack", bus.msg_ack, 1'b0);

    for (int i = 0; i < 5; i++) begin
      sb_q.push_back(vecs[i].exp);
      set_time(vecs[i].bcd);
      sb_check($sformatf("time_vec%0d", i));
    end

    // Single message, request dropped once acked
    bus.msg_data = 24'hABCDEF;
    bus.msg_req  = 1'b1;
    sb_q.push_back(EXP_MSG_ABCDEF);
    @(negedge clk);
    chk("msg1_ack", bus.msg_ack, 1'b1);
    chk("msg1_busy_early", bus.msg_busy, 1'b0);
    bus.msg_req = 1'b0;
    @(negedge clk);
    chk("msg1_ack_once", bus.msg_ack, 1'b0);
    chk("msg1_busy", bus.msg_busy, 1'b1);
    sb_check("msg1_seg");
    ride_msg(EXP_MSG_ABCDEF, dur, errs, acks);
    chk_range("msg1_dur", dur, 40, 60);
    chk("msg1_seg_steady", errs, 0);
    chk("msg1_extra_acks", acks, 0);
    sb_q.push_back(EXP_T235907);
    sb_check("msg1_time_back");

    // Second request and a time update while a message is up
    bus.msg_data = 24'hABCDEF;
    bus.msg_req  = 1'b1;
    @(negedge clk);
    chk("msg2a_ack", bus.msg_ack, 1'b1);
    bus.msg_data = 24'h123456;
    bus.time_bcd = 24'h000000;
    bus.time_valid = 1'b1;
    @(negedge clk);
    bus.time_valid = 1'b0;
    chk("msg2a_busy", bus.msg_busy, 1'b1);
    ride_msg(EXP_MSG_ABCDEF, dur, errs, acks);
    chk("msg2a_seg_kept", errs, 0);
    chk("msg2a_no_ack_in_msg", acks, 0);
    chk("msg2b_ack_first_time", bus.msg_ack, 1'b1);
    sb_q.push_back(EXP_ZERO);
    sb_check("msg2_new_time_shown");
    bus.msg_req = 1'b0;
    @(negedge clk);
    chk("msg2b_busy", bus.msg_busy, 1'b1);
    sb_q.push_back(EXP_MSG_123456);
    sb_check("msg2b_seg");
    ride_msg(EXP_MSG_123456, dur, errs, acks);
    chk("msg2b_seg_steady", errs, 0);
    chk_range("msg2b_dur", dur, 40, 60);
    chk("msg2b_time_back", segs(), EXP_ZERO);

    // Time strobe and request in the same cycle
    bus.time_bcd   = 24'h123456;
    bus.time_valid = 1'b1;
    bus.msg_data   = 24'h000000;
    bus.msg_req    = 1'b1;
    @(negedge clk);
    bus.time_valid = 1'b0;
    bus.msg_req    = 1'b0;
    chk("simul_ack", bus.msg_ack, 1'b1);
    @(negedge clk);
    chk("simul_msg_seg", segs(), EXP_MSG_ZERO);
    ride_msg(EXP_MSG_ZERO, dur, errs, acks);
    chk("simul_msg_steady", errs, 0);
    chk("simul_time_after", segs(), EXP_T123456);

    set_time(24'h235907);
    chk("blink_setup_time", segs(), EXP_T235907);

`ifdef SEG_DISP_BLINK_EN
    bus.edit_field = 2'd2;
    ntr = 0;
    run = 0;
    errs = 0;
    prev_blank = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      s = segs();
      blank2 = (s[23:16] == 8'hFF);
      if (blank2) begin
        if (s[31:24] != 8'hFF) errs++;
      end else if (s[31:16] != 16'h9210) begin
        errs++;
      end
      if ({s[47:32], s[15:0]} != 32'hA430C0F8) errs++;
      if (c > 0 && blank2 != prev_blank) begin
        if (ntr > 0) chk("blink_run_len", run, 20);
        ntr++;
        run = 1;
      end else begin
        run++;
      end
      prev_blank = blank2;
    end
    chk("blink_pair_errors", errs, 0);
    chk_range("blink_transitions", ntr, 3, 6);

    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (segs() == 48'hA430FFFFC0F8) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("blink_found_blank", ok, 1'b1);
    bus.edit_field = 2'd3;
    @(negedge clk);
    @(negedge clk);
    chk("switch_field_visible", segs(), EXP_T235907);
    saw45 = 1'b0;
    errs = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      s = segs();
      if (s == 48'hFFFF9210C0F8) saw45 = 1'b1;
      else if (s != EXP_T235907) errs++;
    end
    chk("hour_field_blinks", saw45, 1'b1);
    chk("hour_field_others", errs, 0);

    bus.edit_field = 2'd0;
    @(negedge clk);
    @(negedge clk);
    errs = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (segs() != EXP_T235907) errs++;
    end
    chk("field_none_steady", errs, 0);
`else
    bus.edit_field = 2'd2;
    errs = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (segs() != EXP_T235907) errs++;
    end
    chk("no_blink_steady", errs, 0);
    bus.edit_field = 2'd0;
`endif

    // Asynchronous reset in the middle of a message
    bus.msg_data = 24'hABCDEF;
    bus.msg_req  = 1'b1;
    @(negedge clk);
    bus.msg_req = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_mid_busy_before", bus.msg_busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_seg", segs(), ALL_BLANK);
    chk("rst_mid_busy", bus.msg_busy, 1'b0);
    chk("rst_mid_ack", bus.msg_ack, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_seg", segs(), EXP_ZERO);
    repeat (5) @(negedge clk);
    chk("rst_release_busy", bus.msg_busy, 1'b0);
    chk("rst_release_seg_hold", segs(), EXP_ZERO);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
